// File: rtl/grf.sv
// grf: 32 x 32-bit register file, two combinational read ports, one write port.
// Optional same-cycle write-to-read forwarding is enabled by defining GRF_BYPASS_EN.
module grf #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [4:0]  A3,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   output logic [31:0] wcnt
);

   // Register 0 has no storage; its reads are forced to zero below.
   logic [31:0] regs_q [1:NREG-1];
   logic [31:0] wcnt_q;
   logic [31:0] wcnt_d;
   logic        wr_en;

   assign wr_en  = WE && (A3 != 5'd0);
   assign wcnt_d = wr_en ? (wcnt_q + 32'd1) : wcnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wcnt_q <= '0;
      end else begin
         if (wr_en) begin
            regs_q[A3] <= WD;
         end
         wcnt_q <= wcnt_d;
      end
   end

`ifdef GRF_BYPASS_EN
   // Forwarding is gated by reset so outputs stay zero while reset is held.
   logic byp_en;
   assign byp_en = reset_n && wr_en;
`endif

   always_comb begin
      RD1 = (A1 == 5'd0) ? 32'h0 : regs_q[A1];
      RD2 = (A2 == 5'd0) ? 32'h0 : regs_q[A2];
`ifdef GRF_BYPASS_EN
      if (byp_en && (A3 == A1)) RD1 = WD;
      if (byp_en && (A3 == A2)) RD2 = WD;
`endif
   end

   assign wcnt = wcnt_q;

endmodule

// File: tb/tb_grf.sv
// Bench for grf: directed steps followed by random traffic against an array model.
// Honours GRF_BYPASS_EN the same way the design does.
module tb_grf;

   logic        clk;
   logic        reset_n;
   logic [4:0]  a1, a2, a3;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd1, rd2, wcnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_wcnt;

   grf dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A1      (a1),
      .A2      (a2),
      .A3      (a3),
      .WE      (we),
      .WD      (wd),
      .RD1     (rd1),
      .RD2     (rd2),
      .wcnt    (wcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] r;
      if (!reset_n || a == 5'd0) r = 32'h0;
      else r = m_regs[a];
`ifdef GRF_BYPASS_EN
      if (reset_n && we && a3 != 5'd0 && a3 == a) r = wd;
`endif
      return r;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_wcnt = 32'h0;
   endtask

   // Commit the currently driven inputs to the model, then cross one edge.
   task automatic tick();
      if (reset_n && we && a3 != 5'd0) begin
         m_regs[a3] = wd;
         m_wcnt = m_wcnt + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [4:0] addr, input logic [31:0] data);
      we = 1'b1; a3 = addr; wd = data;
      tick();
      we = 1'b0;
      #1;
   endtask

   task automatic check_ports(input string tag);
      check({tag, "_rd1"}, rd1, m_read(a1));
      check({tag, "_rd2"}, rd2, m_read(a2));
      check({tag, "_wcnt"}, wcnt, m_wcnt);
   endtask

   initial begin
      logic [31:0] alu_c;
      reset_n = 1'b0;
      a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; we = 1'b0; wd = 32'h0;
      m_reset();
      #1;
      check("rst_rd1", rd1, 32'h0);
      check("rst_wcnt", wcnt, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Preload r5, then assert reset mid-cycle: clears without a clock
      write(5'd5, 32'h1234);
      a1 = 5'd5; #1;
      check("preload_rd1", rd1, 32'h1234);
      check("preload_wcnt", wcnt, 32'd1);
      reset_n = 1'b0;
      m_reset();
      #1;
      check("async_rst_rd1", rd1, 32'h0);
      check("async_rst_wcnt", wcnt, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic write/read
      write(5'd3, 32'hDEAD_BEEF);
      a1 = 5'd3; a2 = 5'd3; #1;
      check("basic_rd1", rd1, 32'hDEAD_BEEF);
      check("basic_rd2", rd2, 32'hDEAD_BEEF);
      check("basic_wcnt", wcnt, 32'd1);

      // Writes to register 0 are dropped
      write(5'd0, 32'hFFFF_FFFF);
      a1 = 5'd0; #1;
      check("zero_rd1", rd1, 32'h0);
      check("zero_wcnt", wcnt, 32'd1);

      // Same-cycle read-after-write
      write(5'd7, 32'h1);
      we = 1'b1; a3 = 5'd7; wd = 32'h2; a1 = 5'd7; #1;
`ifdef GRF_BYPASS_EN
      check("raw_before", rd1, 32'h2);
`else
      check("raw_before", rd1, 32'h1);
`endif
      check("raw_before_model", rd1, m_read(a1));
      tick();
      we = 1'b0; #1;
      check("raw_after", rd1, 32'h2);
      check("raw_wcnt", wcnt, m_wcnt);

      // Reset held across a write edge: the write is lost
      @(negedge clk);
      we = 1'b1; a3 = 5'd9; wd = 32'hAA; a1 = 5'd9;
      #2;
      reset_n = 1'b0;
      m_reset();
      #1;
      check("rstwr_during_rd1", rd1, 32'h0);
      tick();
      we = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rstwr_r9", rd1, 32'h0);
      check("rstwr_wcnt", wcnt, 32'h0);
      @(posedge clk);
      #1;

      // Counter wrap
      force dut.wcnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.wcnt_q;
      m_wcnt = 32'hFFFF_FFFF;
      #1;
      check("wrap_pre", wcnt, 32'hFFFF_FFFF);
      write(5'd4, 32'h55);
      check("wrap_post", wcnt, 32'h0);

      // ALU operand path: arithmetic shift right of r1 by r2
      write(5'd1, 32'h8000_0000);
      write(5'd2, 32'd4);
      a1 = 5'd1; a2 = 5'd2; #1;
      alu_c = $unsigned($signed(rd1) >>> rd2[4:0]);
      check("alu_sra", alu_c, 32'hF800_0000);

      // Back-to-back writes to one address: last wins, each counts
      write(5'd12, 32'h1111);
      write(5'd12, 32'h2222);
      a1 = 5'd12; a2 = 5'd12; #1;
      check_ports("b2b");
      check("b2b_val", rd1, 32'h2222);

      // Random traffic, checked before and after every edge
      for (int n = 0; n < 300; n++) begin
         we = ($urandom_range(0, 3) != 0);
         a3 = 5'($urandom_range(0, 31));
         wd = $urandom;
         a1 = ($urandom_range(0, 4) == 0) ? a3 : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 4) == 0) ? a1 : 5'($urandom_range(0, 31));
         #1;
         check_ports("rand_pre");
         tick();
         we = 1'b0;
         #1;
         check_ports("rand_post");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
